// File: rtl/ifu_pkg.sv
// ifu_pkg: shared widths, default sizing and the buffered fetch entry type
// for the instruction-fetch stage.

package ifu_pkg;

    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DEPTH_DEF   = 2;
    localparam int unsigned MAX_OUT_DEF = 2;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: small synchronous FIFO with push/pop/flush and an occupancy count.
// Serves as the {pc,instr} buffer and, at ADDR_W width, as the in-flight PC
// queue. Pop on empty is ignored; push on full is ignored unless a pop frees
// the slot in the same cycle. Head data is read combinationally.

module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned W     = $bits(fetch_entry_t),
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Next-state for pointers and occupancy.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Control registers; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (!clr_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only slots covered by count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifu_fetch_buffer.sv
// ifu_fetch_buffer: instruction-fetch stage between the PC register and decode.
// Issues in-order imem requests under a credit rule (buffered + outstanding
// never exceeds DEPTH, so responses always have a slot), pairs each response
// with its PC and queues {pc,instr} for decode. A redirect flushes everything
// and the responses still in flight are counted out through drop_cnt.
// Build option IFU_BYPASS_EN: when defined, a response arriving into an empty
// buffer is presented to decode in the same cycle and skips the buffer if
// decode takes it; when undefined decode sees registered entries only.

module ifu_fetch_buffer
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned MAX_OUT = MAX_OUT_DEF
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_step,
    input  logic               redirect,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [INSTR_W-1:0] id_instr
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUT + 1);

    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]     buf_cnt;
    fetch_entry_t      buf_head;
    fetch_entry_t      buf_push_data;
    logic              buf_push, buf_pop, buf_nonempty;
    logic [OW-1:0]     infl_cnt;
    logic [ADDR_W-1:0] infl_pc;

    logic req_ok, credit_ok, rsp_fire, rsp_keep, byp;

    // Issue rule, response classification and decode-side handshake.
    always_comb begin
        credit_ok      = (32'(buf_cnt) + 32'(outstanding_q)) < DEPTH;
        req_ok         = clr_n && !redirect && (drop_cnt_q == '0)
                         && (outstanding_q < OW'(MAX_OUT)) && credit_ok;
        imem_req_valid = req_ok;
        imem_req_addr  = pc_in;
        pc_step        = req_ok && imem_req_ready;

        // A response is only meaningful while something is outstanding.
        rsp_fire = clr_n && imem_rsp_valid && (outstanding_q != '0);
        rsp_keep = rsp_fire && !redirect && (drop_cnt_q == '0) && (infl_cnt != '0);
        buf_nonempty  = buf_cnt != '0;
        buf_push_data = '{pc: infl_pc, instr: imem_rsp_data};
`ifdef IFU_BYPASS_EN
        byp = rsp_keep && !buf_nonempty;
`else
        byp = 1'b0;
`endif
        buf_push = rsp_keep && !(byp && id_ready);
        buf_pop  = clr_n && buf_nonempty && id_ready;

        // Outputs read as zero while held in reset (the reset is synchronous).
        id_valid = clr_n && (buf_nonempty || byp);
        id_pc    = '0;
        id_instr = '0;
        if (clr_n && buf_nonempty) begin
            id_pc    = buf_head.pc;
            id_instr = buf_head.instr;
`ifdef IFU_BYPASS_EN
        end else if (byp) begin
            id_pc    = infl_pc;
            id_instr = imem_rsp_data;
`endif
        end
    end

    // Counter next-state; a redirect re-derives drop_cnt from what is still out.
    always_comb begin
        outstanding_d = outstanding_q + OW'(pc_step) - OW'(rsp_fire);
        drop_cnt_d    = drop_cnt_q;
        if (redirect) begin
            drop_cnt_d = outstanding_q - OW'(rsp_fire);
        end else if (rsp_fire && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - OW'(1);
        end
    end

    // Outstanding-request and drop counters.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    ifu_fifo #(
        .DEPTH (MAX_OUT),
        .W     (ADDR_W)
    ) u_infl (
        .clk         (clk),
        .clr_n       (clr_n),
        .flush_i     (redirect),
        .push_i      (pc_step),
        .push_data_i (pc_in),
        .pop_i       (rsp_fire),
        .head_o      (infl_pc),
        .count_o     (infl_cnt)
    );

    ifu_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_buf (
        .clk         (clk),
        .clr_n       (clr_n),
        .flush_i     (redirect),
        .push_i      (buf_push),
        .push_data_i (buf_push_data),
        .pop_i       (buf_pop),
        .head_o      (buf_head),
        .count_o     (buf_cnt)
    );

endmodule

// File: tb/tb_ifu_fetch_buffer.sv
// tb_ifu_fetch_buffer: directed checks of the fetch stage plus a long
// random-stall run against an in-order imem model and a decode scoreboard.

module tb_ifu_fetch_buffer;
    import ifu_pkg::*;

    localparam int DEPTH   = 2;
    localparam int MAX_OUT = 2;
`ifdef IFU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        clr_n;
    logic [31:0] pc_in;
    logic        pc_step;
    logic        redirect;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    ifu_fetch_buffer #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk            (clk),
        .clr_n          (clr_n),
        .pc_in          (pc_in),
        .pc_step        (pc_step),
        .redirect       (redirect),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        imem_q[$];
    logic [31:0] exp_q[$];
    int          cyc = 0;
    int          lat = 1;
    int          step_cnt = 0;
    int          id_cnt = 0;
    logic [31:0] redir_target = 32'h0;
    int          n_assert = 0;
    int          n_fail = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock: sample handshakes, advance, update imem model/scoreboard, drive next inputs.
    task automatic tick();
        logic        r_req, r_rsp, r_id, r_redir, r_clr, r_step;
        logic [31:0] r_addr, r_idpc, r_idins;
        #1;
        r_req   = imem_req_valid && imem_req_ready;
        r_step  = pc_step;
        r_addr  = imem_req_addr;
        r_rsp   = imem_rsp_valid;
        r_id    = id_valid && id_ready;
        r_idpc  = id_pc;
        r_idins = id_instr;
        r_redir = redirect;
        r_clr   = clr_n;
        if (imem_req_valid) chk32("req_addr", imem_req_addr, pc_in);
        if (r_step) step_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (r_id) begin
            id_cnt++;
            chk1("sb_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                chk32("sb_id_pc", r_idpc, exp_q[0]);
                chk32("sb_id_instr", r_idins, instr_of(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
        if (r_rsp && imem_q.size() != 0) void'(imem_q.pop_front());
        if (!r_clr) begin
            exp_q.delete();
            imem_q.delete();
        end
        if (r_redir) exp_q.delete();
        if (r_req) begin
            exp_q.push_back(r_addr);
            imem_q.push_back('{r_addr, cyc + lat - 1});
        end
        chk1("no_overflow", exp_q.size() <= DEPTH, 1'b1);
        chk1("max_outstanding", imem_q.size() <= MAX_OUT, 1'b1);
        if (r_redir) pc_in = redir_target;
        else if (r_step) pc_in = pc_in + 32'd4;
        redirect = 1'b0;
        if (imem_q.size() != 0 && imem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(imem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic drain();
        int n = 0;
        imem_req_ready = 1'b0;
        id_ready       = 1'b1;
        redirect       = 1'b0;
        while ((exp_q.size() != 0 || imem_q.size() != 0) && n < 30) begin
            tick();
            n++;
        end
        chk32("drain_empty", 32'(exp_q.size() + imem_q.size()), 32'd0);
    endtask

    task automatic wait_id(input string tag, input logic [31:0] pc, input int cycles);
        int n = 0;
        while (!id_valid && n < 12) begin
            tick();
            n++;
        end
        chk32({tag, "_latency"}, 32'(n), 32'(cycles));
        chk32({tag, "_first_pc"}, id_pc, pc);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_n = 1'b0; pc_in = 32'h0; redirect = 1'b0; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; id_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk1("rst_id_valid", id_valid, 1'b0);
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_pc_step", pc_step, 1'b0);
        chk32("rst_id_pc", id_pc, 32'h0);
        chk32("rst_id_instr", id_instr, 32'h0);

        // Free-running imem, latency 1
        lat = 1; clr_n = 1'b1; id_ready = 1'b1; settle();
        chk1("b0_req_valid", imem_req_valid, 1'b1);
        chk1("b0_pc_step", pc_step, 1'b1);
        chk32("b0_req_addr", imem_req_addr, 32'h0);
        chk1("b0_id_valid", id_valid, 1'b0);
        tick();
        chk1("b1_req_valid", imem_req_valid, 1'b1);
        chk32("b1_req_addr", imem_req_addr, 32'h4);
        chk1("b1_id_valid", id_valid, BYP);
        chk32("b1_id_pc", id_pc, 32'h0);
        tick();
        chk1("b2_id_valid", id_valid, 1'b1);
        chk32("b2_id_pc", id_pc, BYP ? 32'h4 : 32'h0);
        chk32("b2_id_instr", id_instr, instr_of(BYP ? 32'h4 : 32'h0));
        chk1("b2_req_valid", imem_req_valid, BYP);
        step_cnt = 0;
        for (int i = 0; i < 12; i++) tick();
        chk32("b_steps_in_12", 32'(step_cnt), BYP ? 32'd12 : 32'd8);

        // Decode stall: buffer fills to DEPTH, issue stops, then resumes in order
        id_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk1("c_stall_req_valid", imem_req_valid, 1'b0);
        chk1("c_stall_id_valid", id_valid, 1'b1);
        chk32("c_stall_head", id_pc, exp_q[0]);
        id_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        // Latency 3, two outstanding, redirect to 0x100
        drain();
        lat = 3; pc_in = 32'h40; imem_req_ready = 1'b1; settle();
        tick(); tick();
        chk1("d_full_credit", imem_req_valid, 1'b0);
        redirect = 1'b1; redir_target = 32'h100; settle();
        chk1("d_redir_step", pc_step, 1'b0);
        tick();
        chk1("d_drop2_req", imem_req_valid, 1'b0);
        chk1("d_drop2_id_valid", id_valid, 1'b0);
        tick();
        chk1("d_drop1_req", imem_req_valid, 1'b0);
        tick();
        chk1("d_resume_req", imem_req_valid, 1'b1);
        chk32("d_resume_addr", imem_req_addr, 32'h100);
        wait_id("d", 32'h100, lat + (BYP ? 0 : 1));

        // Redirect coinciding with the only response
        drain();
        lat = 1; pc_in = 32'h180; imem_req_ready = 1'b1; settle();
        tick();
        imem_req_ready = 1'b0; redirect = 1'b1; redir_target = 32'h200; settle();
        chk1("e_rsp_present", imem_rsp_valid, 1'b1);
        chk1("e_redir_id_valid", id_valid, 1'b0);
        tick();
        imem_req_ready = 1'b1; settle();
        chk1("e_resume_req", imem_req_valid, 1'b1);
        chk32("e_resume_addr", imem_req_addr, 32'h200);
        chk1("e_discarded", id_valid, 1'b0);
        wait_id("e", 32'h200, lat + (BYP ? 0 : 1));

        // Reset mid-stream with a response pending
        drain();
        lat = 3; id_ready = 1'b0; pc_in = 32'h280; imem_req_ready = 1'b1; settle();
        tick(); tick(); tick(); tick();
        chk1("f_pre_id_valid", id_valid, 1'b1);
        clr_n = 1'b0; settle();
        chk1("f_rst_id_valid", id_valid, 1'b0);
        chk32("f_rst_id_pc", id_pc, 32'h0);
        chk32("f_rst_id_instr", id_instr, 32'h0);
        chk1("f_rst_req_valid", imem_req_valid, 1'b0);
        chk1("f_rst_pc_step", pc_step, 1'b0);
        tick();
        clr_n = 1'b1; pc_in = 32'h300; id_ready = 1'b1; settle();
        chk1("f_post_id_valid", id_valid, 1'b0);
        chk1("f_post_req_valid", imem_req_valid, 1'b1);
        chk32("f_post_req_addr", imem_req_addr, 32'h300);
        wait_id("f", 32'h300, lat + (BYP ? 0 : 1));

        // Random stalls and redirects
        drain();
        id_cnt = 0;
        for (int i = 0; i < 10000; i++) begin
            if (i % 500 == 0) lat = int'($urandom_range(1, 3));
            imem_req_ready = ($urandom_range(0, 3) != 0);
            id_ready       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) begin
                redirect     = 1'b1;
                redir_target = $urandom_range(0, 1023) << 2;
            end
            tick();
        end
        drain();
        chk1("g_progress", id_cnt > 1000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
